// File: rtl/ddr3_app_arbiter_if.sv
// Bundles the requester-facing and MIG app-facing signals of the DDR3 app arbiter.
// slave: the arbiter's view. master: the environment's view (engines plus MIG).
interface ddr3_app_arbiter_if #(
    parameter int pADDR_WIDTH   = 30,
    parameter int pMAX_RD_OUTST = 32
);
    localparam int OUT_W = $clog2(pMAX_RD_OUTST + 1);

    logic                   init_calib_complete;
    // write requester
    logic                   wr_req;
    logic [pADDR_WIDTH-1:0] wr_addr;
    logic [63:0]            wr_data;
    logic                   wr_ack;
    // read requester
    logic                   rd_req;
    logic [pADDR_WIDTH-1:0] rd_addr;
    logic                   rd_ack;
    logic [63:0]            rd_resp_data;
    logic                   rd_resp_valid;
    logic [OUT_W-1:0]       rd_outstanding;
    logic                   proto_error;
    // MIG command / write data
    logic [pADDR_WIDTH-1:0] app_addr;
    logic [2:0]             app_cmd;
    logic                   app_en;
    logic [31:0]            app_wdf_data;
    logic                   app_wdf_end;
    logic                   app_wdf_wren;
    logic                   app_rdy;
    logic                   app_wdf_rdy;
    // MIG read return
    logic [31:0]            app_rd_data;
    logic                   app_rd_data_valid;
    logic                   app_rd_data_end;

    modport slave (
        input  init_calib_complete,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  rd_req, rd_addr,
        output rd_ack, rd_resp_data, rd_resp_valid, rd_outstanding, proto_error,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport master (
        output init_calib_complete,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output rd_req, rd_addr,
        input  rd_ack, rd_resp_data, rd_resp_valid, rd_outstanding, proto_error,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Shares the MIG app port between a write requester and a read requester.
// Each 64-bit word goes out as two 32-bit wdf beats and comes back as two rd_data
// beats; this block frames both directions, arbitrates with a bounded burst
// length, and caps the number of reads in flight.
module ddr3_app_arbiter #(
    parameter int pADDR_WIDTH   = 30,
    parameter int pMAX_BURST    = 16,
    parameter int pMAX_RD_OUTST = 32
) (
    input logic              clk,
    input logic              rst_n,
    ddr3_app_arbiter_if.slave bus
);
    localparam int OUT_W   = $clog2(pMAX_RD_OUTST + 1);
    localparam int BURST_W = $clog2(pMAX_BURST + 1);

    localparam logic [OUT_W-1:0]       OUT_MAX   = OUT_W'(pMAX_RD_OUTST);
    localparam logic [OUT_W-1:0]       OUT_ONE   = OUT_W'(1);
    localparam logic [BURST_W-1:0]     BURST_MAX = BURST_W'(pMAX_BURST);
    localparam logic [BURST_W-1:0]     BURST_ONE = BURST_W'(1);
    // word aligned: low three byte-address bits are always issued as zero
    localparam logic [pADDR_WIDTH-1:0] ADDR_MASK = ~pADDR_WIDTH'(7);
    localparam logic [2:0]             CMD_WR    = 3'b000;
    localparam logic [2:0]             CMD_RD    = 3'b001;

    typedef enum logic [1:0] {IDLE, WR0, WR1, RD} state_e;

    state_e                 state_q, state_d;
    logic                   last_wr_q, last_wr_d;   // 1 = last completed grant was a write
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic [pADDR_WIDTH-1:0] app_addr_q, app_addr_d;
    logic [2:0]             app_cmd_q, app_cmd_d;
    logic                   app_en_q, app_en_d;
    logic [31:0]            wdf_data_q, wdf_data_d;
    logic                   wdf_end_q, wdf_end_d;
    logic                   wdf_wren_q, wdf_wren_d;
    logic [OUT_W-1:0]       outst_q, outst_d;
    logic                   lo_held_q, lo_held_d;
    logic [31:0]            lo_data_q, lo_data_d;
    logic [63:0]            resp_data_q, resp_data_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   err_q, err_d;

    logic wr_ack, rd_ack;
    logic cand_w, cand_r, grant_w, grant_r;
    logic ret_dec, ret_err;

    // Arbitration, beat framing and grant bookkeeping. App outputs are registered
    // so they reflect the state being entered.
    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        burst_d    = burst_q;
        app_addr_d = app_addr_q;
        app_cmd_d  = app_cmd_q;
        app_en_d   = app_en_q;
        wdf_data_d = wdf_data_q;
        wdf_end_d  = wdf_end_q;
        wdf_wren_d = wdf_wren_q;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        grant_w    = 1'b0;
        grant_r    = 1'b0;
        cand_w     = bus.wr_req;
        cand_r     = bus.rd_req && (outst_q < OUT_MAX);

        case (state_q)
            IDLE: begin
                if (bus.init_calib_complete) begin
                    if (cand_w && cand_r) begin
                        // a side that has used its full burst yields to the other
                        if (burst_q == BURST_MAX && last_wr_q) grant_r = 1'b1;
                        else                                  grant_w = 1'b1;
                    end else begin
                        grant_w = cand_w;
                        grant_r = cand_r;
                    end
                end
                if (grant_w) begin
                    state_d    = WR0;
                    app_en_d   = 1'b1;
                    wdf_wren_d = 1'b1;
                    app_cmd_d  = CMD_WR;
                    app_addr_d = bus.wr_addr & ADDR_MASK;
                    wdf_data_d = bus.wr_data[31:0];
                    wdf_end_d  = 1'b0;
                end else if (grant_r) begin
                    state_d    = RD;
                    app_en_d   = 1'b1;
                    wdf_wren_d = 1'b0;
                    app_cmd_d  = CMD_RD;
                    app_addr_d = bus.rd_addr & ADDR_MASK;
                end
            end
            WR0: begin
                if (bus.app_rdy && bus.app_wdf_rdy) begin
                    state_d    = WR1;
                    wdf_data_d = bus.wr_data[63:32];
                    wdf_end_d  = 1'b1;
                end
            end
            WR1: begin
                if (bus.app_rdy && bus.app_wdf_rdy) begin
                    wr_ack     = 1'b1;
                    state_d    = IDLE;
                    app_en_d   = 1'b0;
                    wdf_wren_d = 1'b0;
                    wdf_end_d  = 1'b0;
                end
            end
            RD: begin
                if (bus.app_rdy) begin
                    rd_ack   = 1'b1;
                    state_d  = IDLE;
                    app_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // burst length counts completed grants on the current side
        if (wr_ack || rd_ack) begin
            last_wr_d = wr_ack;
            if (last_wr_q != wr_ack)     burst_d = BURST_ONE;
            else if (burst_q != BURST_MAX) burst_d = burst_q + BURST_ONE;
        end
    end

    // Read-return reassembly, outstanding count and sticky protocol error.
    always_comb begin
        lo_held_d    = lo_held_q;
        lo_data_d    = lo_data_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        ret_dec      = 1'b0;
        ret_err      = 1'b0;
        outst_d      = outst_q;

        if (bus.app_rd_data_valid) begin
            if (!bus.app_rd_data_end) begin
                // a second low half overwrites the first but is still an error
                ret_err   = lo_held_q;
                lo_held_d = 1'b1;
                lo_data_d = bus.app_rd_data;
            end else if (!lo_held_q) begin
                ret_err = 1'b1;
            end else begin
                lo_held_d    = 1'b0;
                resp_valid_d = 1'b1;
                resp_data_d  = {bus.app_rd_data, lo_data_q};
                if (outst_q == '0) ret_err = 1'b1;
                else               ret_dec = 1'b1;
            end
        end

        // issue and return in the same cycle cancel out
        if (rd_ack && !ret_dec)      outst_d = outst_q + OUT_ONE;
        else if (!rd_ack && ret_dec) outst_d = outst_q - OUT_ONE;

        err_d = err_q | ret_err;
    end

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_wr_q    <= 1'b0;
            burst_q      <= '0;
            app_addr_q   <= '0;
            app_cmd_q    <= '0;
            app_en_q     <= 1'b0;
            wdf_data_q   <= '0;
            wdf_end_q    <= 1'b0;
            wdf_wren_q   <= 1'b0;
            outst_q      <= '0;
            lo_held_q    <= 1'b0;
            lo_data_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_wr_q    <= last_wr_d;
            burst_q      <= burst_d;
            app_addr_q   <= app_addr_d;
            app_cmd_q    <= app_cmd_d;
            app_en_q     <= app_en_d;
            wdf_data_q   <= wdf_data_d;
            wdf_end_q    <= wdf_end_d;
            wdf_wren_q   <= wdf_wren_d;
            outst_q      <= outst_d;
            lo_held_q    <= lo_held_d;
            lo_data_q    <= lo_data_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.wr_ack         = wr_ack;
    assign bus.rd_ack         = rd_ack;
    assign bus.rd_resp_data   = resp_data_q;
    assign bus.rd_resp_valid  = resp_valid_q;
    assign bus.rd_outstanding = outst_q;
    assign bus.proto_error    = err_q;
    assign bus.app_addr       = app_addr_q;
    assign bus.app_cmd        = app_cmd_q;
    assign bus.app_en         = app_en_q;
    assign bus.app_wdf_data   = wdf_data_q;
    assign bus.app_wdf_end    = wdf_end_q;
    assign bus.app_wdf_wren   = wdf_wren_q;
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Scoreboard bench for ddr3_app_arbiter with a small behavioural MIG model.
module tb_ddr3_app_arbiter;
    localparam int AW = 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ddr3_app_arbiter_if #(.pADDR_WIDTH(AW), .pMAX_RD_OUTST(32)) bus ();

    ddr3_app_arbiter #(.pADDR_WIDTH(AW), .pMAX_BURST(4), .pMAX_RD_OUTST(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          last;
    } beat_t;

    beat_t         exp_beats[$];
    logic          exp_grant[$];   // 1 = write ack, 0 = read ack
    logic [63:0]   exp_resp[$];
    int            total = 0;
    int            bad = 0;
    int            n_wr_ack = 0;
    int            n_rd_ack = 0;
    int            n_resp = 0;

    // MIG model state
    logic [63:0]   mem [logic [AW-1:0]];
    logic [AW-1:0] rq[$];
    logic [31:0]   wlo;
    bit            ret_en = 1'b1;
    bit            inj_end = 1'b0;

    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D3 = 64'hA5A5A5A5_5A5A5A5A;
    localparam logic [63:0] D5 = 64'hDEADBEEF_CAFEF00D;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [AW-1:0] al(logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = ~AW'(7);
        return a & m;
    endfunction

    task automatic expect_write(logic [AW-1:0] a, logic [63:0] d, bit with_grant);
        exp_beats.push_back('{3'b000, al(a), d[31:0], 1'b0});
        exp_beats.push_back('{3'b000, al(a), d[63:32], 1'b1});
        if (with_grant) exp_grant.push_back(1'b1);
    endtask

    task automatic expect_read(logic [AW-1:0] a, logic [63:0] d);
        exp_beats.push_back('{3'b001, al(a), 32'h0, 1'b0});
        exp_grant.push_back(1'b0);
        exp_resp.push_back(d);
    endtask

    // Monitor: command beats, acks and responses checked against the queues;
    // accepted commands also feed the MIG model.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (bus.app_en && bus.app_rdy && (bus.app_cmd != 3'b000 || bus.app_wdf_rdy)) begin
                if (exp_beats.size() == 0) fail_now("unexpected_app_beat");
                else begin
                    b = exp_beats.pop_front();
                    check("beat_cmd", 64'(bus.app_cmd), 64'(b.cmd));
                    check("beat_addr", 64'(bus.app_addr), 64'(b.addr));
                    if (b.cmd == 3'b000) begin
                        check("beat_wdata", 64'(bus.app_wdf_data), 64'(b.data));
                        check("beat_wend", 64'(bus.app_wdf_end), 64'(b.last));
                        check("beat_wren", 64'(bus.app_wdf_wren), 64'd1);
                    end
                end
                if (bus.app_cmd == 3'b001) rq.push_back(bus.app_addr);
                else if (!bus.app_wdf_end) wlo = bus.app_wdf_data;
                else mem[bus.app_addr] = {bus.app_wdf_data, wlo};
            end
            if (bus.wr_ack || bus.rd_ack) begin
                if (bus.wr_ack) n_wr_ack++;
                if (bus.rd_ack) n_rd_ack++;
                if (exp_grant.size() == 0) fail_now("unexpected_ack");
                else check("grant_side", 64'(bus.wr_ack), 64'(exp_grant.pop_front()));
                if (bus.wr_ack && bus.rd_ack) fail_now("both_acks");
            end
            if (bus.rd_resp_valid) begin
                n_resp++;
                if (exp_resp.size() == 0) fail_now("unexpected_resp");
                else check("resp_data", bus.rd_resp_data, exp_resp.pop_front());
            end
        end
    end

    // MIG read return: two beats per queued read, or one injected stray end beat.
    initial begin
        logic [AW-1:0] a;
        logic [63:0]   d;
        bus.app_rd_data       = '0;
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data_end   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.app_rd_data_valid = 1'b0;
            bus.app_rd_data_end   = 1'b0;
            if (inj_end) begin
                inj_end = 1'b0;
                bus.app_rd_data       = 32'h0BAD0BAD;
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data_end   = 1'b1;
            end else if (ret_en && rq.size() > 0) begin
                a = rq.pop_front();
                d = mem.exists(a) ? mem[a] : 64'h0;
                bus.app_rd_data       = d[31:0];
                bus.app_rd_data_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.app_rd_data       = d[63:32];
                bus.app_rd_data_end   = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(logic [AW-1:0] a, logic [63:0] d, output int cyc);
        expect_write(a, d, 1'b1);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus.wr_ack && cyc < 50);
        if (!bus.wr_ack) fail_now("wr_ack_timeout");
        step();
        bus.wr_req = 1'b0;
    endtask

    task automatic do_read(logic [AW-1:0] a, logic [63:0] d);
        int cyc;
        expect_read(a, d);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus.rd_ack && cyc < 50);
        if (!bus.rd_ack) fail_now("rd_ack_timeout");
        step();
        bus.rd_req = 1'b0;
    endtask

    task automatic drain(string nm, int limit);
        int cyc = 0;
        while ((bus.rd_outstanding != 0 || exp_resp.size() != 0) && cyc < limit) begin
            step();
            cyc++;
        end
        check(nm, 64'(bus.rd_outstanding), 64'd0);
        check({nm, "_resp_q"}, 64'(exp_resp.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_wr0(string nm);
        int cyc = 0;
        do begin @(negedge clk); cyc++; end
        while (!(bus.app_en && !bus.app_wdf_end) && cyc < 50);
        if (!(bus.app_en && !bus.app_wdf_end)) fail_now(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, acks, r0, a0;
        rst_n                   = 1'b0;
        bus.init_calib_complete = 1'b0;
        bus.wr_req              = 1'b0;
        bus.wr_addr             = '0;
        bus.wr_data             = '0;
        bus.rd_req              = 1'b0;
        bus.rd_addr             = '0;
        bus.app_rdy             = 1'b1;
        bus.app_wdf_rdy         = 1'b1;
        repeat (3) step();

        // reset state
        check("rst_app_en", 64'(bus.app_en), 64'd0);
        check("rst_wdf_wren", 64'(bus.app_wdf_wren), 64'd0);
        check("rst_wr_ack", 64'(bus.wr_ack), 64'd0);
        check("rst_rd_ack", 64'(bus.rd_ack), 64'd0);
        check("rst_resp_valid", 64'(bus.rd_resp_valid), 64'd0);
        check("rst_outstanding", 64'(bus.rd_outstanding), 64'd0);
        check("rst_proto_error", 64'(bus.proto_error), 64'd0);
        check("rst_app_addr", 64'(bus.app_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // no grants before calibration completes
        bus.rd_req = 1'b1;
        bus.rd_addr = 30'h40;
        repeat (6) step();
        check("calib_low_app_en", 64'(bus.app_en), 64'd0);
        bus.rd_req = 1'b0;
        bus.init_calib_complete = 1'b1;
        step();

        // 1: single write, two beats, ack in cycle 3
        do_write(30'h40, D1, cyc);
        check("t1_wr_ack_cycle", 64'(cyc), 64'd3);

        // 2: readback with unaligned address forced to 0x40
        r0 = n_resp;
        do_read(30'h47, D1);
        drain("t2_outstanding", 50);
        check("t2_resp_count", 64'(n_resp - r0), 64'd1);
        check("t2_proto_error", 64'(bus.proto_error), 64'd0);

        // 3: both requesting continuously, burst limit 4
        pulse_reset();
        bus.init_calib_complete = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) expect_read(30'h40, D1);
            else            expect_write(30'h80, D3, 1'b1);
        end
        bus.wr_addr = 30'h80;
        bus.wr_data = D3;
        bus.rd_addr = 30'h40;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        acks = 0;
        cyc  = 0;
        while (acks < 10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.wr_ack || bus.rd_ack) acks++;
        end
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        check("t3_ack_count", 64'(acks), 64'd10);
        check("t3_grants_left", 64'(exp_grant.size()), 64'd0);
        drain("t3_outstanding", 100);

        // 4: no returns, reads cap at 32 outstanding
        ret_en = 1'b0;
        for (int i = 0; i < 32; i++) expect_read(30'h40, D1);
        r0 = n_resp;
        bus.rd_addr = 30'h40;
        bus.rd_req  = 1'b1;
        acks = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.rd_ack) acks++;
        end
        check("t4_rd_acks", 64'(acks), 64'd32);
        check("t4_outstanding_max", 64'(bus.rd_outstanding), 64'd32);
        check("t4_stalled_app_en", 64'(bus.app_en), 64'd0);
        step();
        bus.rd_req = 1'b0;
        ret_en = 1'b1;
        drain("t4_outstanding", 400);
        check("t4_resp_count", 64'(n_resp - r0), 64'd32);

        // 5: app_rdy low for 5 cycles during the second beat
        expect_write(30'hC0, D5, 1'b1);
        bus.wr_addr = 30'hC0;
        bus.wr_data = D5;
        bus.wr_req  = 1'b1;
        a0 = n_wr_ack;
        wait_wr0("t5_wr0_timeout");
        step();
        bus.app_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_data", 64'(bus.app_wdf_data), 64'hDEADBEEF);
            check("t5_hold_end", 64'(bus.app_wdf_end), 64'd1);
            check("t5_no_ack", 64'(bus.wr_ack), 64'd0);
        end
        step();
        bus.app_rdy = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus.wr_ack && cyc < 20);
        step();
        bus.wr_req = 1'b0;
        repeat (3) step();
        check("t5_single_ack", 64'(n_wr_ack - a0), 64'd1);

        // 6: stray end beat sets sticky error; reset mid-WR1 clears everything
        inj_end = 1'b1;
        repeat (3) step();
        check("t6_proto_error", 64'(bus.proto_error), 64'd1);
        exp_beats.push_back('{3'b000, 30'h100, 32'h33333333, 1'b0});
        bus.wr_addr = 30'h100;
        bus.wr_data = 64'h44444444_33333333;
        bus.wr_req  = 1'b1;
        a0 = n_wr_ack;
        wait_wr0("t6_wr0_timeout");
        step();
        bus.app_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_error_sticky", 64'(bus.proto_error), 64'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_app_en", 64'(bus.app_en), 64'd0);
        check("t6_rst_wdf_wren", 64'(bus.app_wdf_wren), 64'd0);
        check("t6_rst_proto_error", 64'(bus.proto_error), 64'd0);
        check("t6_rst_wr_ack", 64'(bus.wr_ack), 64'd0);
        bus.wr_req  = 1'b0;
        bus.app_rdy = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("t6_no_ack_after_abort", 64'(n_wr_ack - a0), 64'd0);
        check("t6_app_en_idle", 64'(bus.app_en), 64'd0);

        check("end_beats_left", 64'(exp_beats.size()), 64'd0);
        check("end_grants_left", 64'(exp_grant.size()), 64'd0);
        check("end_resps_left", 64'(exp_resp.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
